// File: rtl/hilo_mul_unit.sv
// rtl/hilo_mul_unit.sv - HI/LO multiply-accumulate unit (MULT/MULTU/MADD/MSUB/MTHI/MTLO)
// Optional single-cycle product: define HILO_FAST_MUL_EN; default is 32-step shift-add.
module hilo_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t               state, state_nx;
  logic [2*WIDTH-1:0]   prod;
  logic                 neg;
  logic [1:0]           op_q;

  logic                 is_signed;
  logic                 launch_mul;
  logic                 launch_mt;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   p_final;
  logic [2*WIDTH-1:0]   acc_result;

`ifndef HILO_FAST_MUL_EN
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
`endif

  // Flush in IDLE also suppresses any same-edge launch.
  assign is_signed  = (op != 3'b001);
  assign launch_mul = start && !flush && (op[2] == 1'b0);
  assign launch_mt  = start && !flush && (op == 3'b100 || op == 3'b101);

  // Magnitude form: -0x80000000 wraps to 0x80000000, which is the correct magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign p_final = neg ? -prod : prod;

  always_comb begin
    acc_result = p_final;
    case (op_q)
      2'b10:   acc_result = {hi, lo} + p_final;
      2'b11:   acc_result = {hi, lo} - p_final;
      default: acc_result = p_final;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (launch_mul) begin
`ifdef HILO_FAST_MUL_EN
          state_nx = ACC;
`else
          state_nx = MUL;
`endif
        end
      end
      MUL: begin
`ifndef HILO_FAST_MUL_EN
        if (flush)                           state_nx = IDLE;
        else if (cnt == CW'(WIDTH - 1))      state_nx = ACC;
`else
        state_nx = IDLE;
`endif
      end
      ACC:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      op_q   <= '0;
`ifndef HILO_FAST_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_mul) begin
            neg  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            op_q <= op[1:0];
`ifdef HILO_FAST_MUL_EN
            prod <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            cnt    <= '0;
`endif
          end else if (launch_mt) begin
            if (op[0]) lo <= a;
            else       hi <= a;
            done <= 1'b1;
          end
        end
`ifndef HILO_FAST_MUL_EN
        MUL: begin
          if (!flush) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
`endif
        ACC: begin
          if (!flush) begin
            {hi, lo} <= acc_result;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// tb/tb_hilo_mul_unit.sv - directed self-checking bench for hilo_mul_unit
// Latency expectations follow HILO_FAST_MUL_EN when defined.
module tb_hilo_mul_unit;

`ifdef HILO_FAST_MUL_EN
  localparam int LAT = 1;
  localparam int IGN_J = 0;
  localparam int FLUSH_J = 0;
  localparam int RST_E = 0;
`else
  localparam int LAT = 33;
  localparam int IGN_J = 4;
  localparam int FLUSH_J = 9;
  localparam int RST_E = 15;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail = 0;

  hilo_mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_check(input string tag, input int elapsed,
                              input logic [31:0] ehi, input logic [31:0] elo);
    int nb = 0;
    int nd = 0;
    bit got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (done) nd++;
      end else begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, " completes"}, 64'(got), 64'd1);
    chk({tag, " busy_cycles"}, 64'(nb), 64'(LAT - elapsed));
    chk({tag, " done_while_busy"}, 64'(nd), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] x,
                    input logic [31:0] ehi, input logic [31:0] elo);
    launch(o, x, 32'h0);
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, " done_fall"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset0 hi", 64'(hi), 64'd0);
    chk("reset0 lo", 64'(lo), 64'd0);
    chk("reset0 busy", 64'(busy), 64'd0);
    chk("reset0 done", 64'(done), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Load nonzero state, then apply reset mid-cycle.
    mt("mthi_pre", 3'b100, 32'hAAAA5555, 32'hAAAA5555, 32'h0);
    mt("mtlo_pre", 3'b101, 32'h12345678, 32'hAAAA5555, 32'h12345678);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("reset_mid hi", 64'(hi), 64'd0);
    chk("reset_mid lo", 64'(lo), 64'd0);
    chk("reset_mid busy", 64'(busy), 64'd0);
    chk("reset_mid done", 64'(done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle5 hi", 64'(hi), 64'd0);
    chk("idle5 lo", 64'(lo), 64'd0);
    chk("idle5 busy", 64'(busy), 64'd0);
    chk("idle5 done", 64'(done), 64'd0);

    launch(3'b000, 32'hFFFFFFFF, 32'h00000002);
    finish_check("mult_m1x2", 0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    launch(3'b001, 32'hFFFFFFFF, 32'h00000002);
    finish_check("multu_ffx2", 0, 32'h00000001, 32'hFFFFFFFE);
    launch(3'b000, 32'hFFFFFFFD, 32'h00000005);
    finish_check("mult_m3x5", 0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    launch(3'b000, 32'h80000000, 32'h80000000);
    finish_check("mult_min_min", 0, 32'h40000000, 32'h00000000);

    mt("mthi5", 3'b100, 32'd5, 32'd5, 32'h00000000);
    mt("mtlo3", 3'b101, 32'd3, 32'd5, 32'd3);
    launch(3'b010, 32'd2, 32'd3);
    finish_check("madd_2x3", 0, 32'd5, 32'd9);
    launch(3'b011, 32'h80000000, 32'h80000000);
    finish_check("msub_min", 0, 32'hC0000005, 32'h00000009);

    // Reserved op: nothing happens.
    launch(3'b110, 32'hDEADBEEF, 32'h1);
    @(negedge clk);
    chk("rsvd busy", 64'(busy), 64'd0);
    chk("rsvd done", 64'(done), 64'd0);
    chk("rsvd hi", 64'(hi), 64'hC0000005);
    chk("rsvd lo", 64'(lo), 64'h00000009);

    // A start while busy must not disturb the in-flight operands.
    launch(3'b000, 32'd7, 32'd9);
    repeat (IGN_J + 1) @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    finish_check("mult_ignore_start", IGN_J + 1, 32'd0, 32'd63);

    // Flush mid-operation: HI/LO hold, no Done.
    launch(3'b000, 32'd7, 32'd9);
    repeat (IGN_J + 1) @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'h11111111; b = 32'h22222222;
    if (FLUSH_J == IGN_J) flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    if (FLUSH_J > IGN_J) begin
      repeat (FLUSH_J - IGN_J) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush busy", 64'(busy), 64'd0);
      chk("flush no_done", 64'(done), 64'd0);
    end
    chk("flush hi", 64'(hi), 64'd0);
    chk("flush lo", 64'(lo), 64'd63);
    launch(3'b000, 32'd3, 32'd4);
    finish_check("mult_3x4_after_flush", 0, 32'd0, 32'd12);

    // Reset during a MADD.
    launch(3'b010, 32'd100, 32'd100);
    repeat (RST_E) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_madd hi", 64'(hi), 64'd0);
    chk("rst_madd lo", 64'(lo), 64'd0);
    chk("rst_madd busy", 64'(busy), 64'd0);
    chk("rst_madd done", 64'(done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    launch(3'b000, 32'd3, 32'd4);
    finish_check("mult_3x4_after_rst", 0, 32'd0, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
